// File: rtl/bcd_seg_scan.sv
// Time-multiplexed 7-segment scanner for packed BCD digits with per-frame snapshot,
// leading-zero blanking and '-' for non-BCD codes. All outputs are registered.
module bcd_seg_scan #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter bit          ACTIVE_LOW  = 1'b1,
    parameter bit          LZ_BLANK    = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done
);

    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CntW = $clog2(REFRESH_DIV);

    localparam logic [6:0]            SegOff = {7{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AnOff  = {NUM_DIGITS{ACTIVE_LOW}};

    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [IdxW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   snap_q, snap_d;
    logic [NUM_DIGITS-1:0]     snap_dp_q, snap_dp_d;
    logic                      first_q, first_d;
    logic [6:0]                seg_q, seg_d;
    logic                      dp_q, dp_d;
    logic [NUM_DIGITS-1:0]     an_q, an_d;
    logic                      fd_q, fd_d;

    logic                      terminal, last;
    logic [3:0]                cur_digit;
    logic                      cur_dp;
    logic                      blank;
    logic [6:0]                seg_act;
    logic [NUM_DIGITS-1:0]     an_act;

    assign terminal = (cnt_q == CntW'(REFRESH_DIV - 1));
    assign last     = (idx_q == IdxW'(NUM_DIGITS - 1));

    // Scan counters and snapshot; everything holds while disabled.
    always_comb begin
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        snap_dp_d = snap_dp_q;
        first_d   = first_q;
        fd_d      = 1'b0;
        if (enable) begin
            first_d = 1'b0;
            if (terminal) begin
                cnt_d = '0;
                idx_d = last ? '0 : idx_q + IdxW'(1);
                fd_d  = last;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
            if (first_q || (terminal && last)) begin
                snap_d    = digits_in;
                snap_dp_d = dp_in;
            end
        end
    end

    // Current digit select, leading-zero detection and one-hot anode.
    always_comb begin
        cur_digit = 4'd0;
        cur_dp    = 1'b0;
        an_act    = '0;
        blank     = LZ_BLANK && (idx_q != '0);
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx_q == IdxW'(i)) begin
                cur_digit = snap_q[4*i +: 4];
                cur_dp    = snap_dp_q[i];
                an_act[i] = 1'b1;
            end
            if (i >= int'(idx_q) && snap_q[4*i +: 4] != 4'd0) begin
                blank = 1'b0;
            end
        end
    end

    always_comb begin
        unique case (cur_digit)
            4'd0:    seg_act = 7'h3F;
            4'd1:    seg_act = 7'h06;
            4'd2:    seg_act = 7'h5B;
            4'd3:    seg_act = 7'h4F;
            4'd4:    seg_act = 7'h66;
            4'd5:    seg_act = 7'h6D;
            4'd6:    seg_act = 7'h7D;
            4'd7:    seg_act = 7'h07;
            4'd8:    seg_act = 7'h7F;
            4'd9:    seg_act = 7'h6F;
            default: seg_act = 7'h40;
        endcase
        if (blank) begin
            seg_act = 7'h00;
        end
    end

    always_comb begin
        seg_d = SegOff;
        dp_d  = ACTIVE_LOW;
        an_d  = AnOff;
        if (enable) begin
            seg_d = seg_act ^ SegOff;
            dp_d  = cur_dp ^ ACTIVE_LOW;
            an_d  = an_act ^ AnOff;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            snap_q    <= '0;
            snap_dp_q <= '0;
            first_q   <= 1'b1;
            seg_q     <= SegOff;
            dp_q      <= ACTIVE_LOW;
            an_q      <= AnOff;
            fd_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            snap_dp_q <= snap_dp_d;
            first_q   <= first_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
            fd_q      <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Randomized self-checking bench for bcd_seg_scan against a frame-level reference model.
module tb_bcd_seg_scan;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [15:0]  digits_in;
    logic [3:0]   dp_in;
    logic [6:0]   seg;
    logic         dp;
    logic [3:0]   an;
    logic         frame_done;

    int n_cmp = 0;
    int n_bad = 0;
    int fd_seen;

    bcd_seg_scan #(
        .NUM_DIGITS (N),
        .REFRESH_DIV(DIV),
        .ACTIVE_LOW (1'b1),
        .LZ_BLANK   (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: what the display should show, per clock, from the rules.
    logic [6:0] seg_tab [16];
    int         m_cnt, m_idx;
    logic [15:0] m_snap;
    logic [3:0]  m_dps;
    bit          m_first, m_wrap;
    logic [6:0]  e_seg;
    logic        e_dp, e_fd;
    logic [3:0]  e_an;

    initial begin
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    end

    function automatic logic [6:0] glyph(input logic [15:0] s, input int i);
        logic [15:0] upper;
        upper = s >> (4 * i);
        if (i > 0 && upper == 16'h0) return 7'h00;
        return seg_tab[upper[3:0]];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt = 0; m_idx = 0; m_snap = '0; m_dps = '0; m_first = 1'b1;
            e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_fd = 1'b0;
        end else if (!enable) begin
            e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_fd = 1'b0;
        end else begin
            e_seg  = ~glyph(m_snap, m_idx);
            e_dp   = ~m_dps[m_idx];
            e_an   = ~(4'b0001 << m_idx);
            m_wrap = (m_cnt == DIV - 1) && (m_idx == N - 1);
            e_fd   = m_wrap;
            if (m_cnt == DIV - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % N;
            end else begin
                m_cnt++;
            end
            if (m_first || m_wrap) begin
                m_snap = digits_in;
                m_dps  = dp_in;
            end
            m_first = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("seg", 32'(seg), 32'(e_seg));
            check("dp", 32'(dp), 32'(e_dp));
            check("an", 32'(an), 32'(e_an));
            check("frame_done", 32'(frame_done), 32'(e_fd));
            if (frame_done === 1'b1) fd_seen++;
        end
    endtask

    function automatic logic [15:0] rand_digits();
        logic [15:0] v;
        if ($urandom_range(0, 3) == 0) return 16'($urandom);
        v = '0;
        for (int i = 0; i < $urandom_range(0, 4); i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    initial begin
        reset = 1'b1; enable = 1'b0; digits_in = '0; dp_in = '0;
        repeat (3) @(negedge clk);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'h1);
        check("rst_an", 32'(an), 32'hF);
        check("rst_fd", 32'(frame_done), 32'h0);

        reset = 1'b0; enable = 1'b1; digits_in = 16'h1234;
        step(1);
        check("first_an", 32'(an), 32'hE);
        step(3);
        fd_seen = 0;
        step(32);
        check("fd_per_2_frames", 32'(fd_seen), 32'd2);

        digits_in = 16'h0050; step(20);
        digits_in = 16'h0000; step(20);
        digits_in = 16'h1234; step(24);
        digits_in = 16'h5678; step(24);          // changes mid-frame
        digits_in = 16'h00A0; dp_in = 4'b0100; step(36);

        step(1);
        enable = 1'b0; step(10);
        check("stall_an", 32'(an), 32'hF);
        enable = 1'b1; step(20);

        #2 reset = 1'b1;
        #1;
        check("async_seg", 32'(seg), 32'h7F);
        check("async_an", 32'(an), 32'hF);
        check("async_dp", 32'(dp), 32'h1);
        step(2);
        reset = 1'b0;

        for (int c = 0; c < 400; c++) begin
            step(1);
            if ($urandom_range(0, 7) == 0) digits_in = rand_digits();
            if ($urandom_range(0, 7) == 0) dp_in = 4'($urandom);
            enable = ($urandom_range(0, 11) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
